// File: rtl/alu_exec_unit_if.sv
// Request/response channel bundle for alu_exec_unit: issue-side request handshake,
// consumer-side response handshake and the unit's status outputs.
interface alu_exec_unit_if #(
    parameter int WORD_SIZE = 32,
    parameter int TAG_W     = 4
);
    logic                 req_valid;
    logic                 req_ready;
    logic [WORD_SIZE-1:0] req_in1;
    logic [WORD_SIZE-1:0] req_in2;
    logic [4:0]           req_func;
    logic [TAG_W-1:0]     req_tag;

    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [WORD_SIZE-1:0] rsp_out;
    logic [TAG_W-1:0]     rsp_tag;
    logic                 rsp_err;

    logic                 busy;
    logic [15:0]          ops_done;

    modport master (
        output req_valid, req_in1, req_in2, req_func, req_tag, rsp_ready,
        input  req_ready, rsp_valid, rsp_out, rsp_tag, rsp_err, busy, ops_done
    );

    modport slave (
        input  req_valid, req_in1, req_in2, req_func, req_tag, rsp_ready,
        output req_ready, rsp_valid, rsp_out, rsp_tag, rsp_err, busy, ops_done
    );
endinterface

// File: rtl/alu_exec_unit.sv
// Handshaked front-end for the combinational Alu: requests are evaluated on the accept
// edge and the tagged results are queued in an in-order response FIFO.
module alu_exec_unit #(
    parameter int WORD_SIZE = 32,
    parameter int DEPTH     = 4,
    parameter int TAG_W     = 4
) (
    input  logic           clk,
    input  logic           reset,
    alu_exec_unit_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    // Function codes shared with the Alu; bit 4 marks the comparison group.
    localparam logic [4:0] FUNC_ADD  = 5'h00;
    localparam logic [4:0] FUNC_SUB  = 5'h01;
    localparam logic [4:0] FUNC_AND  = 5'h04;
    localparam logic [4:0] FUNC_XOR  = 5'h06;
    localparam logic [4:0] FUNC_MVHI = 5'h0B;
    localparam logic [4:0] FUNC_NAND = 5'h0C;
    localparam logic [4:0] FUNC_NOR  = 5'h0D;
    localparam logic [4:0] FUNC_XNOR = 5'h0E;
    localparam logic [4:0] FUNC_F    = 5'h10;
    localparam logic [4:0] FUNC_EQ   = 5'h11;

    typedef struct packed {
        logic [WORD_SIZE-1:0] out;
        logic [TAG_W-1:0]     tag;
        logic                 err;
    } entry_t;

    entry_t               mem [DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     count;
    logic [15:0]          ops_cnt;
    logic                 req_ready_int;
    logic                 rsp_valid_int;
    logic                 push;
    logic                 pop;
    logic [WORD_SIZE-1:0] alu_out;
    logic                 alu_err;

    // MVHI places operand 2 in the upper half of the word; unsupported codes yield 0.
    always_comb begin
        alu_out = '0;
        alu_err = 1'b0;
        case (bus.req_func)
            FUNC_ADD:  alu_out = bus.req_in1 + bus.req_in2;
            FUNC_SUB:  alu_out = bus.req_in1 - bus.req_in2;
            FUNC_AND:  alu_out = bus.req_in1 & bus.req_in2;
            FUNC_XOR:  alu_out = bus.req_in1 ^ bus.req_in2;
            FUNC_NAND: alu_out = ~(bus.req_in1 & bus.req_in2);
            FUNC_NOR:  alu_out = ~(bus.req_in1 | bus.req_in2);
            FUNC_XNOR: alu_out = ~(bus.req_in1 ^ bus.req_in2);
            FUNC_MVHI: alu_out = bus.req_in2 << (WORD_SIZE / 2);
            FUNC_F:    alu_out = '0;
            FUNC_EQ:   alu_out = {{(WORD_SIZE-1){1'b0}}, (bus.req_in1 == bus.req_in2)};
            default:   alu_err = 1'b1;
        endcase
    end

    // Ready looks only at the registered count, so a full FIFO blocks even while popping.
    assign req_ready_int = !reset && (count < DEPTH_CNT);
    assign rsp_valid_int = !reset && (count != '0);
    assign push          = bus.req_valid && req_ready_int;
    assign pop           = rsp_valid_int && bus.rsp_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ops_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr  <= rd_ptr + PTR_W'(1);
                ops_cnt <= ops_cnt + 16'd1;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{out: alu_out, tag: bus.req_tag, err: alu_err};
        end
    end

    assign bus.req_ready = req_ready_int;
    assign bus.rsp_valid = rsp_valid_int;
    assign bus.busy      = rsp_valid_int;
    assign bus.ops_done  = ops_cnt;
    assign bus.rsp_out   = rsp_valid_int ? mem[rd_ptr].out : '0;
    assign bus.rsp_tag   = rsp_valid_int ? mem[rd_ptr].tag : '0;
    assign bus.rsp_err   = rsp_valid_int ? mem[rd_ptr].err : 1'b0;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed scenarios plus a randomized run
// compared against a queue-based behavioural model of the unit.
module tb_alu_exec_unit;
    localparam int DEPTH = 4;

    localparam logic [4:0] F_ADD  = 5'h00;
    localparam logic [4:0] F_SUB  = 5'h01;
    localparam logic [4:0] F_AND  = 5'h04;
    localparam logic [4:0] F_XOR  = 5'h06;
    localparam logic [4:0] F_MVHI = 5'h0B;
    localparam logic [4:0] F_NAND = 5'h0C;
    localparam logic [4:0] F_NOR  = 5'h0D;
    localparam logic [4:0] F_XNOR = 5'h0E;
    localparam logic [4:0] F_F    = 5'h10;
    localparam logic [4:0] F_EQ   = 5'h11;

    typedef struct {
        logic [31:0] out;
        logic [3:0]  tag;
        logic        err;
    } rsp_t;

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    rsp_t exp_q[$];
    logic [15:0] ops_model;

    alu_exec_unit_if #(.WORD_SIZE(32), .TAG_W(4)) bus ();

    alu_exec_unit #(.WORD_SIZE(32), .DEPTH(DEPTH), .TAG_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    // Result of one operation as the Alu is meant to define it.
    function automatic void ref_alu(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] o, output logic er);
        er = 1'b0;
        case (f)
            F_ADD:   o = a + b;
            F_SUB:   o = a - b;
            F_AND:   o = a & b;
            F_XOR:   o = a ^ b;
            F_NAND:  o = ~(a & b);
            F_NOR:   o = ~(a | b);
            F_XNOR:  o = ~(a ^ b);
            F_MVHI:  o = b * 32'd65536;
            F_F:     o = 32'd0;
            F_EQ:    o = (a == b) ? 32'd1 : 32'd0;
            default: begin o = 32'd0; er = 1'b1; end
        endcase
    endfunction

    // Drives one cycle of inputs, advances the model across the coming edge, waits for the next negedge.
    task automatic cycle(input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] f, input logic [3:0] t, input logic rr);
        rsp_t e;
        bit   acc;
        bit   pp;
        bus.req_valid = v;
        bus.req_in1   = a;
        bus.req_in2   = b;
        bus.req_func  = f;
        bus.req_tag   = t;
        bus.rsp_ready = rr;
        acc = v && (exp_q.size() < DEPTH) && !reset;
        pp  = rr && (exp_q.size() > 0) && !reset;
        if (pp) begin
            e = exp_q.pop_front();
            ops_model = ops_model + 16'd1;
        end
        if (acc) begin
            ref_alu(f, a, b, e.out, e.err);
            e.tag = t;
            exp_q.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.req_valid = 1'b0; bus.req_in1 = '0; bus.req_in2 = '0;
        bus.req_func = '0; bus.req_tag = '0; bus.rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (bus.req_ready !== 1'b0) begin failures++; $display("[TB] FAIL rst_req_ready got=%b exp=0", bus.req_ready); end
        checks++; if (bus.rsp_valid !== 1'b0) begin failures++; $display("[TB] FAIL rst_rsp_valid got=%b exp=0", bus.rsp_valid); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL rst_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.ops_done !== 16'd0) begin failures++; $display("[TB] FAIL rst_ops_done got=%0d exp=0", bus.ops_done); end
        checks++; if ({bus.rsp_out, bus.rsp_tag, bus.rsp_err} !== 37'd0) begin failures++; $display("[TB] FAIL rst_head got=%h/%h/%b exp=0", bus.rsp_out, bus.rsp_tag, bus.rsp_err); end
        reset = 1'b0;
        #1;
        checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("[TB] FAIL rst_release_ready got=%b exp=1", bus.req_ready); end
        @(negedge clk);
    endtask

    task automatic test_add_latency();
        cycle(1'b1, 32'd3, 32'd5, F_ADD, 4'd1, 1'b1);
        checks++; if (bus.rsp_valid !== 1'b1) begin failures++; $display("[TB] FAIL add_valid got=%b exp=1", bus.rsp_valid); end
        checks++; if (bus.rsp_out !== 32'd8) begin failures++; $display("[TB] FAIL add_out got=%h exp=8", bus.rsp_out); end
        checks++; if (bus.rsp_tag !== 4'd1) begin failures++; $display("[TB] FAIL add_tag got=%h exp=1", bus.rsp_tag); end
        checks++; if (bus.rsp_err !== 1'b0) begin failures++; $display("[TB] FAIL add_err got=%b exp=0", bus.rsp_err); end
        cycle(1'b0, 32'd0, 32'd0, F_ADD, 4'd0, 1'b1);
        checks++; if (bus.rsp_valid !== 1'b0) begin failures++; $display("[TB] FAIL add_drained got=%b exp=0", bus.rsp_valid); end
        checks++; if (bus.ops_done !== 16'd1) begin failures++; $display("[TB] FAIL add_ops_done got=%0d exp=1", bus.ops_done); end
    endtask

    task automatic test_back_to_back();
        cycle(1'b1, 32'd3, 32'd5, F_SUB, 4'd2, 1'b1);
        checks++; if ({bus.rsp_out, bus.rsp_tag} !== {32'hFFFFFFFE, 4'd2}) begin failures++; $display("[TB] FAIL b2b_sub got=%h/%h exp=fffffffe/2", bus.rsp_out, bus.rsp_tag); end
        cycle(1'b1, 32'd3, 32'd5, F_EQ, 4'd3, 1'b1);
        checks++; if ({bus.rsp_valid, bus.rsp_out, bus.rsp_tag} !== {1'b1, 32'd0, 4'd3}) begin failures++; $display("[TB] FAIL b2b_eq_ne got=%b/%h/%h exp=1/0/3", bus.rsp_valid, bus.rsp_out, bus.rsp_tag); end
        cycle(1'b1, 32'd3, 32'd3, F_EQ, 4'd4, 1'b1);
        checks++; if ({bus.rsp_valid, bus.rsp_out, bus.rsp_tag} !== {1'b1, 32'd1, 4'd4}) begin failures++; $display("[TB] FAIL b2b_eq_eq got=%b/%h/%h exp=1/1/4", bus.rsp_valid, bus.rsp_out, bus.rsp_tag); end
        cycle(1'b0, 32'd0, 32'd0, F_ADD, 4'd0, 1'b1);
        checks++; if (bus.rsp_valid !== 1'b0) begin failures++; $display("[TB] FAIL b2b_drained got=%b exp=0", bus.rsp_valid); end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_out;
        for (int i = 0; i < 5; i++) begin
            checks++; if (bus.req_ready !== (i < DEPTH)) begin failures++; $display("[TB] FAIL fill_ready_%0d got=%b exp=%b", i, bus.req_ready, (i < DEPTH)); end
            cycle(1'b1, 32'(i), 32'(2 * i), F_ADD, 4'(i), 1'b0);
        end
        checks++; if ({bus.req_ready, bus.rsp_valid, bus.rsp_tag, bus.rsp_out} !== {1'b0, 1'b1, 4'd0, 32'd0}) begin failures++; $display("[TB] FAIL full_state got=%b/%b/%h/%h exp=0/1/0/0", bus.req_ready, bus.rsp_valid, bus.rsp_tag, bus.rsp_out); end
        cycle(1'b1, 32'd4, 32'd8, F_ADD, 4'd4, 1'b1);
        checks++; if ({bus.req_ready, bus.busy, bus.rsp_tag, bus.rsp_out} !== {1'b1, 1'b1, 4'd1, 32'd3}) begin failures++; $display("[TB] FAIL full_pop_no_push got=%b/%b/%h/%h exp=1/1/1/3", bus.req_ready, bus.busy, bus.rsp_tag, bus.rsp_out); end
        cycle(1'b1, 32'd4, 32'd8, F_ADD, 4'd4, 1'b1);
        for (int k = 2; k <= 4; k++) begin
            exp_out = 32'(3 * k);
            checks++; if ({bus.rsp_valid, bus.rsp_tag, bus.rsp_out} !== {1'b1, 4'(k), exp_out}) begin failures++; $display("[TB] FAIL drain_%0d got=%b/%h/%h exp=1/%h/%h", k, bus.rsp_valid, bus.rsp_tag, bus.rsp_out, k, exp_out); end
            cycle(1'b0, 32'd0, 32'd0, F_ADD, 4'd0, 1'b1);
        end
        checks++; if (bus.rsp_valid !== 1'b0) begin failures++; $display("[TB] FAIL drain_empty got=%b exp=0", bus.rsp_valid); end
    endtask

    task automatic test_unsupported();
        cycle(1'b1, 32'd123, 32'd456, 5'h1F, 4'd7, 1'b1);
        checks++; if ({bus.rsp_err, bus.rsp_out, bus.rsp_tag} !== {1'b1, 32'd0, 4'd7}) begin failures++; $display("[TB] FAIL unsup_head got=%b/%h/%h exp=1/0/7", bus.rsp_err, bus.rsp_out, bus.rsp_tag); end
        cycle(1'b1, 32'd10, 32'd20, F_ADD, 4'd8, 1'b1);
        checks++; if ({bus.rsp_err, bus.rsp_out, bus.rsp_tag} !== {1'b0, 32'd30, 4'd8}) begin failures++; $display("[TB] FAIL unsup_next_add got=%b/%h/%h exp=0/1e/8", bus.rsp_err, bus.rsp_out, bus.rsp_tag); end
        cycle(1'b0, 32'd0, 32'd0, F_ADD, 4'd0, 1'b1);
    endtask

    task automatic test_random();
        logic [4:0]  funcs [10];
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  f;
        bit          exp_v;
        funcs = '{F_ADD, F_SUB, F_AND, F_XOR, F_NAND, F_NOR, F_XNOR, F_MVHI, F_F, F_EQ};
        for (int n = 0; n < 400; n++) begin
            exp_v = (exp_q.size() > 0);
            checks++; if (bus.rsp_valid !== exp_v) begin failures++; $display("[TB] FAIL rnd_valid n=%0d got=%b exp=%b", n, bus.rsp_valid, exp_v); end
            checks++; if (bus.req_ready !== (exp_q.size() < DEPTH)) begin failures++; $display("[TB] FAIL rnd_ready n=%0d got=%b exp=%b", n, bus.req_ready, (exp_q.size() < DEPTH)); end
            checks++; if (bus.ops_done !== ops_model) begin failures++; $display("[TB] FAIL rnd_ops_done n=%0d got=%0d exp=%0d", n, bus.ops_done, ops_model); end
            if (exp_v) begin
                checks++; if ({bus.rsp_out, bus.rsp_tag, bus.rsp_err} !== {exp_q[0].out, exp_q[0].tag, exp_q[0].err}) begin failures++; $display("[TB] FAIL rnd_head n=%0d got=%h/%h/%b exp=%h/%h/%b", n, bus.rsp_out, bus.rsp_tag, bus.rsp_err, exp_q[0].out, exp_q[0].tag, exp_q[0].err); end
            end else begin
                checks++; if ({bus.rsp_out, bus.rsp_tag, bus.rsp_err} !== 37'd0) begin failures++; $display("[TB] FAIL rnd_empty_head n=%0d got=%h/%h/%b exp=0", n, bus.rsp_out, bus.rsp_tag, bus.rsp_err); end
            end
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            f = ($urandom_range(0, 7) == 0) ? 5'($urandom) : funcs[$urandom_range(0, 9)];
            cycle(($urandom_range(0, 3) != 0), a, b, f, 4'($urandom), ($urandom_range(0, 2) != 0));
        end
    endtask

    task automatic test_reset_midstream();
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 32'(i + 10), 32'd1, F_ADD, 4'(i), 1'b0);
        end
        cycle(1'b0, 32'd0, 32'd0, F_ADD, 4'd0, 1'b0);
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("[TB] FAIL mid_busy_before got=%b exp=1", bus.busy); end
        #2 reset = 1'b1;
        #1;
        exp_q.delete();
        ops_model = 16'd0;
        checks++; if ({bus.rsp_valid, bus.busy, bus.req_ready} !== 3'b000) begin failures++; $display("[TB] FAIL mid_reset_flags got=%b/%b/%b exp=0/0/0", bus.rsp_valid, bus.busy, bus.req_ready); end
        checks++; if (bus.ops_done !== 16'd0) begin failures++; $display("[TB] FAIL mid_reset_ops got=%0d exp=0", bus.ops_done); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("[TB] FAIL mid_release_ready got=%b exp=1", bus.req_ready); end
        cycle(1'b1, 32'd1, 32'd1, F_ADD, 4'd5, 1'b0);
        checks++; if ({bus.rsp_valid, bus.rsp_out, bus.rsp_tag} !== {1'b1, 32'd2, 4'd5}) begin failures++; $display("[TB] FAIL mid_add got=%b/%h/%h exp=1/2/5", bus.rsp_valid, bus.rsp_out, bus.rsp_tag); end
        cycle(1'b0, 32'd0, 32'd0, F_ADD, 4'd0, 1'b1);
        checks++; if ({bus.rsp_valid, bus.ops_done} !== {1'b0, 16'd1}) begin failures++; $display("[TB] FAIL mid_final got=%b/%0d exp=0/1", bus.rsp_valid, bus.ops_done); end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        ops_model = 16'd0;
        test_reset();
        test_add_latency();
        test_back_to_back();
        test_backpressure();
        test_unsupported();
        test_random();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
